// File: rtl/cdf_pkg.sv
// Shared types and default widths for the multi-channel CDF accumulator.
package cdf_pkg;

    localparam int DEF_DATA_W = 20;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cdf_channel_acc.sv
// One channel of the CDF accumulator: running sum with clamp/wrap, sticky
// overflow flag and capture of the first non-zero cumulative value.
module cdf_channel_acc
    import cdf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SATURATE = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load,
    input  logic              first,
    input  logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] cdf,
    output logic [DATA_W-1:0] cdf_min,
    output logic              cdf_min_valid,
    output logic              sat_flag
);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] res;
    logic              ovf;
    logic              nz;

    // The output register doubles as the accumulator; a frame start adds onto zero.
    always_comb begin
        base = first ? '0 : cdf;
        sum  = {1'b0, base} + {1'b0, count};
        ovf  = sum[DATA_W];
        if (ovf && (SATURATE != 0)) res = '1;
        else                        res = sum[DATA_W-1:0];
        nz   = |res;
    end

    // Update sum, flags and min on each accepted beat; frame start re-seeds flags.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            cdf           <= '0;
            cdf_min       <= '0;
            cdf_min_valid <= 1'b0;
            sat_flag      <= 1'b0;
        end else if (load) begin
            cdf      <= res;
            sat_flag <= (first ? 1'b0 : sat_flag) | ovf;
            if (first) begin
                // res is zero when nz is low, so min stays 0 for an all-zero bin
                cdf_min_valid <= nz;
                cdf_min       <= res;
            end else if (!cdf_min_valid && nz) begin
                cdf_min_valid <= 1'b1;
                cdf_min       <= res;
            end
        end
    end

endmodule

// File: rtl/cdf_accumulate_mc.sv
// Multi-channel CDF accumulator top: frame FSM, one-deep output handshake
// register and the address/last pipeline; per-channel math in cdf_channel_acc.
module cdf_accumulate_mc
    import cdf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_CH   = 3,
    parameter int SATURATE = 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_count,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_cdf,
    output logic [ADDR_W-1:0]        out_addr,
    output logic                     out_last,
    output logic [NUM_CH*DATA_W-1:0] cdf_min,
    output logic [NUM_CH-1:0]        cdf_min_valid,
    output logic [NUM_CH-1:0]        sat_flag,
    output logic                     done
);

    state_t state;
    state_t state_nxt;
    logic   accept;
    logic   first;

    assign in_ready = (!out_valid || out_ready) && !clear;
    assign accept   = in_valid && in_ready;
    // A beat accepted while the previous frame's last beat is leaving the
    // output register starts a new frame even though state is still RUN.
    assign first    = (state != RUN) || (out_valid && out_last);
    assign done     = (state == DONE);

    // State register; reset and clear both return to IDLE.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) state <= IDLE;
        else                   state <= state_nxt;
    end

    // Next state: any accepted beat means a frame is running; the last beat
    // leaving the output with nothing new behind it ends the frame.
    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = RUN;
        else if (out_valid && out_ready && out_last)
            state_nxt = DONE;
    end

    // Output valid plus address/last pipeline, held while the consumer stalls.
    always_ff @(posedge clock) begin
        if (!reset_n || clear) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_addr  <= in_addr;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        cdf_channel_acc #(
            .DATA_W   (DATA_W),
            .SATURATE (SATURATE)
        ) u_acc (
            .clock         (clock),
            .reset_n       (reset_n),
            .clear         (clear),
            .load          (accept),
            .first         (first),
            .count         (in_count[c*DATA_W +: DATA_W]),
            .cdf           (out_cdf[c*DATA_W +: DATA_W]),
            .cdf_min       (cdf_min[c*DATA_W +: DATA_W]),
            .cdf_min_valid (cdf_min_valid[c]),
            .sat_flag      (sat_flag[c])
        );
    end

endmodule

// File: tb/tb_cdf_accumulate_mc.sv
// Directed bench for cdf_accumulate_mc: a saturating and a wrapping instance
// share the same stimulus; expected values are hand-computed constants.
module tb_cdf_accumulate_mc;

    localparam int DW = 20;
    localparam int AW = 16;
    localparam int NC = 3;

    logic            clock = 1'b0;
    logic            reset_n;
    logic            clear;
    logic            in_valid;
    logic [NC*DW-1:0] in_count;
    logic [AW-1:0]   in_addr;
    logic            in_last;
    logic            out_ready;

    logic            in_ready, out_valid, out_last, done;
    logic [NC*DW-1:0] out_cdf, cdf_min;
    logic [AW-1:0]   out_addr;
    logic [NC-1:0]   cdf_min_valid, sat_flag;

    logic            in_ready_w, out_valid_w, out_last_w, done_w;
    logic [NC*DW-1:0] out_cdf_w, cdf_min_w;
    logic [AW-1:0]   out_addr_w;
    logic [NC-1:0]   cdf_min_valid_w, sat_flag_w;

    int errs = 0;
    int chks = 0;

    always #5 clock = ~clock;

    cdf_accumulate_mc #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .SATURATE(1)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_count(in_count),
        .in_addr(in_addr), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_cdf(out_cdf),
        .out_addr(out_addr), .out_last(out_last), .cdf_min(cdf_min),
        .cdf_min_valid(cdf_min_valid), .sat_flag(sat_flag), .done(done)
    );

    cdf_accumulate_mc #(.DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .SATURATE(0)) dut_w (
        .clock(clock), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_count(in_count),
        .in_addr(in_addr), .in_last(in_last),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_cdf(out_cdf_w),
        .out_addr(out_addr_w), .out_last(out_last_w), .cdf_min(cdf_min_w),
        .cdf_min_valid(cdf_min_valid_w), .sat_flag(sat_flag_w), .done(done_w)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ch(input logic [NC*DW-1:0] v, input int c);
        return v[c*DW +: DW];
    endfunction

    // Present one beat for one clock edge, then look at the registered result.
    task automatic beat(input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                        input logic [DW-1:0] c2, input logic [AW-1:0] a, input logic l);
        in_valid = 1'b1;
        in_count = {c2, c1, c0};
        in_addr  = a;
        in_last  = l;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clock); #1;
    endtask

    initial begin
        reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_count = '0;
        in_addr = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_cdf", 64'(out_cdf), 64'd0);
        chk("rst_out_addr", 64'(out_addr), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_cdf_min", 64'(cdf_min), 64'd0);
        chk("rst_min_valid", 64'(cdf_min_valid), 64'd0);
        chk("rst_sat", 64'(sat_flag), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        #1 chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Basic frame: ch0 {0,0,5,3}, ch1 {1,2,3,4}, ch2 {0,7,0,0}
        beat(0, 1, 0, 16'h10, 0);
        chk("f1b0_valid", 64'(out_valid), 64'd1);
        chk("f1b0_ch0", 64'(ch(out_cdf, 0)), 64'd0);
        chk("f1b0_ch1", 64'(ch(out_cdf, 1)), 64'd1);
        chk("f1b0_addr", 64'(out_addr), 64'h10);
        chk("f1b0_mval", 64'(cdf_min_valid), 64'b010);
        beat(0, 2, 7, 16'h11, 0);
        chk("f1b1_ch1", 64'(ch(out_cdf, 1)), 64'd3);
        chk("f1b1_ch2", 64'(ch(out_cdf, 2)), 64'd7);
        chk("f1b1_mval", 64'(cdf_min_valid), 64'b110);
        chk("f1b1_min1", 64'(ch(cdf_min, 1)), 64'd1);
        beat(5, 3, 0, 16'h12, 0);
        chk("f1b2_ch0", 64'(ch(out_cdf, 0)), 64'd5);
        chk("f1b2_mval", 64'(cdf_min_valid), 64'b111);
        chk("f1b2_min0", 64'(ch(cdf_min, 0)), 64'd5);
        chk("f1b2_done", 64'(done), 64'd0);
        beat(3, 4, 0, 16'h13, 1);
        chk("f1b3_ch0", 64'(ch(out_cdf, 0)), 64'd8);
        chk("f1b3_ch1", 64'(ch(out_cdf, 1)), 64'd10);
        chk("f1b3_ch2", 64'(ch(out_cdf, 2)), 64'd7);
        chk("f1b3_last", 64'(out_last), 64'd1);
        idle_cycle();
        chk("f1_done", 64'(done), 64'd1);
        chk("f1_valid_drop", 64'(out_valid), 64'd0);
        chk("f1_min0_hold", 64'(ch(cdf_min, 0)), 64'd5);
        chk("f1_min2_hold", 64'(ch(cdf_min, 2)), 64'd7);

        // Channel 1 all zeros; frame starts from DONE
        beat(3, 0, 1, 16'h20, 0);
        chk("f2b0_ch0", 64'(ch(out_cdf, 0)), 64'd3);
        chk("f2b0_done", 64'(done), 64'd0);
        beat(2, 0, 0, 16'h21, 1);
        chk("f2b1_ch0", 64'(ch(out_cdf, 0)), 64'd5);
        chk("f2_mval", 64'(cdf_min_valid), 64'b101);
        chk("f2_min1", 64'(ch(cdf_min, 1)), 64'd0);
        chk("f2_min0", 64'(ch(cdf_min, 0)), 64'd3);
        chk("f2_min2", 64'(ch(cdf_min, 2)), 64'd1);

        // Overflow: 0xFFFF0 + 0x20, clamp vs wrap; back-to-back with previous frame
        beat(20'hFFFF0, 0, 0, 16'h30, 0);
        chk("f3b0_ch0", 64'(ch(out_cdf, 0)), 64'hFFFF0);
        chk("f3b0_sat", 64'(sat_flag), 64'd0);
        chk("f3b0_min0", 64'(ch(cdf_min, 0)), 64'hFFFF0);
        beat(20'h20, 0, 0, 16'h31, 1);
        chk("f3b1_clamp", 64'(ch(out_cdf, 0)), 64'hFFFFF);
        chk("f3b1_sat", 64'(sat_flag), 64'b001);
        chk("f3b1_wrap", 64'(ch(out_cdf_w, 0)), 64'h00010);
        chk("f3b1_sat_w", 64'(sat_flag_w), 64'b001);

        // Back-to-back frame: sums restart, min/flags re-seeded on first beat
        beat(1, 0, 0, 16'h40, 0);
        chk("f4b0_ch0", 64'(ch(out_cdf, 0)), 64'd1);
        chk("f4b0_ch0_w", 64'(ch(out_cdf_w, 0)), 64'd1);
        chk("f4b0_sat", 64'(sat_flag), 64'd0);
        chk("f4b0_sat_w", 64'(sat_flag_w), 64'd0);
        chk("f4b0_min0", 64'(ch(cdf_min, 0)), 64'd1);
        chk("f4b0_mval", 64'(cdf_min_valid), 64'b001);
        chk("f4b0_done", 64'(done), 64'd0);
        beat(2, 0, 0, 16'h41, 1);
        chk("f4b1_ch0", 64'(ch(out_cdf, 0)), 64'd3);
        idle_cycle();
        chk("f4_done", 64'(done), 64'd1);

        // Stall: ch0 {2,4,6,1}, consumer stalls 3 cycles holding bin 1
        beat(2, 0, 0, 16'h50, 0);
        beat(4, 0, 0, 16'h51, 0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_count  = {20'd0, 20'd0, 20'd6};
        in_addr   = 16'h52;
        in_last   = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_ch0", 64'(ch(out_cdf, 0)), 64'd6);
            chk("stall_addr", 64'(out_addr), 64'h51);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("unstall_ch0", 64'(ch(out_cdf, 0)), 64'd12);
        chk("unstall_addr", 64'(out_addr), 64'h52);
        beat(1, 0, 0, 16'h53, 1);
        chk("stall_final", 64'(ch(out_cdf, 0)), 64'd13);
        idle_cycle();

        // Reset mid-frame after bin 2
        beat(7, 1, 1, 16'h60, 0);
        beat(7, 1, 1, 16'h61, 0);
        beat(7, 1, 1, 16'h62, 0);
        reset_n = 1'b0;
        idle_cycle();
        chk("mrst_valid", 64'(out_valid), 64'd0);
        chk("mrst_cdf", 64'(out_cdf), 64'd0);
        chk("mrst_min", 64'(cdf_min), 64'd0);
        chk("mrst_mval", 64'(cdf_min_valid), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        beat(4, 0, 0, 16'h70, 0);
        chk("mrst_b0", 64'(ch(out_cdf, 0)), 64'd4);
        beat(1, 0, 0, 16'h71, 1);
        chk("mrst_b1", 64'(ch(out_cdf, 0)), 64'd5);
        chk("mrst_min0", 64'(ch(cdf_min, 0)), 64'd4);
        idle_cycle();

        // Clear together with in_valid after bin 2: beat dropped
        beat(1, 1, 1, 16'h80, 0);
        beat(1, 1, 1, 16'h81, 0);
        beat(1, 1, 1, 16'h82, 0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_count = {20'd9, 20'd9, 20'd9};
        #1 chk("clr_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", 64'(out_valid), 64'd0);
        chk("clr_cdf", 64'(out_cdf), 64'd0);
        chk("clr_addr", 64'(out_addr), 64'd0);
        chk("clr_mval", 64'(cdf_min_valid), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        idle_cycle();
        chk("clr_no_beat", 64'(out_valid), 64'd0);
        beat(4, 0, 0, 16'h90, 0);
        chk("clr_b0", 64'(ch(out_cdf, 0)), 64'd4);
        beat(1, 0, 0, 16'h91, 1);
        chk("clr_b1", 64'(ch(out_cdf, 0)), 64'd5);
        chk("clr_min0", 64'(ch(cdf_min, 0)), 64'd4);
        idle_cycle();
        chk("clr_done_end", 64'(done), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end

endmodule

// File: doc/cdf_accumulate_mc.md
CDF_ACCUMULATE_MC -- requirements
Module: cdf_accumulate_mc

Interface
REQ-001 Parameter DATA_W, default 20: bit width of each per-channel histogram count and cumulative sum.
REQ-002 Parameter ADDR_W, default 16: bin/store address width.
REQ-003 Parameter NUM_CH, default 3: number of independent channels accumulated in lockstep.
REQ-004 Parameter SATURATE, default 1: 1 = clamp sums at all-ones; 0 = wrap modulo 2^DATA_W.
REQ-005 clock  input  1  single clock; all logic on rising edge.
REQ-006 reset_n  input  1  reset, synchronous, active-low.
REQ-007 clear  input  1  synchronous frame restart; same effect as reset on all state and outputs.
REQ-008 in_valid / in_ready  input / output  1 / 1  input beat handshake; transfer when both are high.
REQ-009 in_count  input  NUM_CH*DATA_W  per-channel histogram bin counts; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-010 in_addr  input  ADDR_W  store address travelling with the beat.
REQ-011 in_last  input  1  marks the final bin of the frame.
REQ-012 out_valid / out_ready  output / input  1 / 1  output beat handshake.
REQ-013 out_cdf  output  NUM_CH*DATA_W  per-channel cumulative sums including the current bin.
REQ-014 out_addr, out_last  output  ADDR_W, 1  in_addr and in_last delayed to align with out_cdf.
REQ-015 cdf_min  output  NUM_CH*DATA_W  per-channel first non-zero cumulative value of the frame.
REQ-016 cdf_min_valid  output  NUM_CH  per-channel flag; high once cdf_min for that channel is captured.
REQ-017 sat_flag  output  NUM_CH  sticky per-channel flag: clamp (SATURATE=1) or wrap (SATURATE=0) occurred.
REQ-018 done  output  1  high in state DONE.

Function
REQ-019 FSM states SHALL be IDLE, RUN and DONE; reset and clear SHALL both force IDLE.
REQ-020 Transitions: IDLE->RUN on first accepted beat; RUN->DONE when the beat with out_last=1 transfers on the output; DONE->RUN on the next accepted input beat, which starts a new frame.
REQ-021 in_ready SHALL equal (!out_valid || out_ready) && !clear; no other backpressure source.
REQ-022 Latency SHALL be one cycle: an accepted beat SHALL appear on out_* in the next cycle with out_valid=1.
REQ-023 out_* SHALL hold stable while out_valid && !out_ready; out_valid SHALL drop after a transfer with no new beat accepted.
REQ-024 Per channel: out_cdf[c] = acc[c] + in_count[c], and the result SHALL become the new acc[c].
REQ-025 On the first beat of a frame (accepted in IDLE or DONE), acc[c] SHALL be taken as 0 before the add.
REQ-026 Sum overflow: SATURATE=1 yields all-ones; SATURATE=0 yields the low DATA_W bits; either way sat_flag[c] SHALL set and stay set.
REQ-027 cdf_min[c] SHALL capture the first non-zero out_cdf[c] of the frame, with cdf_min_valid[c] set in the same cycle as out_valid.
REQ-028 cdf_min[c] and cdf_min_valid[c] SHALL then hold until the first beat of the next frame, or until reset or clear.
REQ-029 On the first beat of a new frame, cdf_min, cdf_min_valid and sat_flag SHALL clear, then re-evaluate against that beat.
REQ-030 A channel whose counts are all zero for the whole frame SHALL keep cdf_min_valid[c]=0 and cdf_min[c]=0.
REQ-031 clear asserted together with in_valid SHALL drop the beat (in_ready=0) and take priority.
REQ-032 A beat with in_last=1 accepted in IDLE SHALL be a complete one-bin frame.

Reset
REQ-033 On reset_n=0 at a clock edge: state=IDLE, out_valid=0, out_cdf=0, out_addr=0, out_last=0, cdf_min=0, cdf_min_valid=0, sat_flag=0, done=0, acc=0.
REQ-034 Reset mid-frame SHALL discard all partial sums; the next accepted beat starts a new frame.

Structure
REQ-035 Package cdf_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default DATA_W and ADDR_W constants.
REQ-036 Per-channel add, clamp/wrap, sat flag and min capture SHALL live in sub-module cdf_channel_acc, instantiated NUM_CH times via generate.
REQ-037 The top level SHALL own the FSM, the handshake and the address/last pipeline register.

Verification
REQ-038 Counts ch0={0,0,5,3}, last on bin 3, out_ready=1 -> out_cdf ch0={0,0,5,8}; cdf_min=5 with valid set on the bin-2 output; done after bin 3.
REQ-039 out_ready=0 for 3 cycles mid-frame -> in_ready=0, out_* stable, no beat lost or duplicated, sums match the unstalled run.
REQ-040 DATA_W=20, SATURATE=1, counts 0xFFFF0 then 0x20 -> out_cdf 0xFFFFF, sat_flag=1; with SATURATE=0 -> 0x00010, sat_flag=1.
REQ-041 Channel 1 all zeros, channels 0 and 2 non-zero -> cdf_min_valid=3'b101, cdf_min[1]=0.
REQ-042 reset_n=0 (and separately clear=1 with in_valid=1) after bin 2 -> all outputs 0, state IDLE; next frame {4,1} -> out_cdf {4,5}, cdf_min=4.
REQ-043 Two back-to-back frames with no idle cycle -> second frame sums start from 0; cdf_min, cdf_min_valid and sat_flag reset on its first beat.
